// File: rtl/scarf_byte_master.sv
// scarf_byte_master: byte-stream command master driving a SCARF register-map slave
module scarf_byte_master #(
    parameter int LEN_W = 6
) (
    input  logic             clk,
    input  logic             rst_sync,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [6:0]       cmd_slave_id,
    input  logic             cmd_rnw,
    input  logic [5:0]       cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [7:0]       wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [7:0]       rd_data,
    output logic [7:0]       bus_data,
    output logic             bus_valid,
    output logic             bus_finished,
    output logic [6:0]       bus_slave_id,
    output logic             bus_rnw,
    input  logic [7:0]       bus_rdata,
    output logic             busy,
    output logic             done,
    output logic             nack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]       state, state_nx;
    logic [LEN_W-1:0] cnt, cnt_nx;
    logic [6:0]       lat_id, id_nx;
    logic             lat_rnw, rnw_nx;
    logic             cmd_fire, echo_ok, rd_cap, rd_valid_nx, rd_pulse, wr_pulse;

    // Next-state, pulse decisions and byte-count bookkeeping
    always_comb begin
        cmd_fire    = cmd_valid && cmd_ready;
        echo_ok     = bus_rdata == {1'b0, lat_id};
        rd_cap      = state == S_DATA && lat_rnw && bus_valid;
        rd_valid_nx = (rd_valid && !rd_ready) || rd_cap;
        id_nx       = cmd_fire ? cmd_slave_id : lat_id;
        rnw_nx      = cmd_fire ? cmd_rnw : lat_rnw;
        state_nx    = state == S_IDLE ? (cmd_fire ? S_ADDR : S_IDLE) :
                      state == S_ADDR ? (((lat_rnw && !echo_ok) || cnt == '0) ? S_FIN : S_DATA) :
                      state == S_DATA ? ((cnt == '0 && !(lat_rnw && rd_valid_nx)) ? S_FIN : S_DATA) :
                      S_IDLE;
        rd_pulse    = state_nx == S_DATA && lat_rnw && cnt != '0 && !rd_valid_nx;
        wr_pulse    = state == S_DATA && !lat_rnw && wr_valid && wr_ready;
        cnt_nx      = cmd_fire ? cmd_len : cnt - LEN_W'(rd_pulse || wr_pulse);
    end

    // Registered state and outputs, all derived from the next-cycle view
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state        <= S_IDLE;
            cnt          <= '0;
            lat_id       <= '0;
            lat_rnw      <= 1'b0;
            cmd_ready    <= 1'b1;
            wr_ready     <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= 8'h00;
            bus_data     <= 8'h00;
            bus_valid    <= 1'b0;
            bus_finished <= 1'b0;
            bus_slave_id <= 7'h00;
            bus_rnw      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            nack         <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            lat_id       <= id_nx;
            lat_rnw      <= rnw_nx;
            cmd_ready    <= state_nx == S_IDLE;
            busy         <= state_nx != S_IDLE;
            wr_ready     <= state_nx == S_DATA && !lat_rnw && cnt_nx != '0;
            rd_valid     <= rd_valid_nx;
            rd_data      <= rd_cap ? bus_rdata : rd_data;
            bus_valid    <= state_nx == S_ADDR || rd_pulse || wr_pulse;
            bus_data     <= state_nx == S_ADDR ? {2'b00, cmd_addr} : (wr_pulse ? wr_data : 8'h00);
            bus_finished <= state_nx == S_FIN;
            done         <= state_nx == S_FIN;
            bus_slave_id <= state_nx == S_IDLE ? 7'h00 : id_nx;
            bus_rnw      <= state_nx == S_IDLE ? 1'b0 : rnw_nx;
            nack         <= (state == S_ADDR && lat_rnw) ? !echo_ok : nack;
        end
    end

endmodule

// File: tb/tb_scarf_byte_master.sv
// tb_scarf_byte_master: table-driven scoreboard bench with a regmap echo/read model
module tb_scarf_byte_master;

    localparam int LEN_W = 6;

    typedef struct {
        logic       rnw;
        logic [6:0] id;
        logic [5:0] addr;
        int         len;
        logic [7:0] echo;
        logic [7:0] d [8];
        int         stall_byte;
        int         stall_cyc;
        logic       exp_nack;
        int         exp_pulses;
    } txn_t;

    logic             clk = 1'b0;
    logic             rst_sync = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [6:0]       cmd_slave_id = 7'h00;
    logic             cmd_rnw = 1'b0;
    logic [5:0]       cmd_addr = 6'h00;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [7:0]       wr_data = 8'h00;
    logic             rd_valid;
    logic             rd_ready = 1'b1;
    logic [7:0]       rd_data;
    logic [7:0]       bus_data;
    logic             bus_valid;
    logic             bus_finished;
    logic [6:0]       bus_slave_id;
    logic             bus_rnw;
    logic [7:0]       bus_rdata;
    logic             busy;
    logic             done;
    logic             nack;

    scarf_byte_master #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_sync(rst_sync),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_slave_id(cmd_slave_id),
        .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .bus_data(bus_data), .bus_valid(bus_valid), .bus_finished(bus_finished),
        .bus_slave_id(bus_slave_id), .bus_rnw(bus_rnw), .bus_rdata(bus_rdata),
        .busy(busy), .done(done), .nack(nack)
    );

    always #5 clk = ~clk;

    // Regmap model: slot 0 is the slave-ID echo, then one byte per read pulse
    logic [7:0] src [0:127];
    int         src_idx = 0;
    int         cyc = 0;
    assign bus_rdata = (bus_valid && bus_rnw) ? src[src_idx] : 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_sync || (cmd_valid && cmd_ready)) src_idx <= 0;
        else if (bus_valid && bus_rnw) src_idx <= (src_idx < 127) ? src_idx + 1 : 127;
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    logic [7:0] exp_bus [$];
    logic [7:0] exp_rd  [$];
    logic       mon_en = 1'b0;
    logic [6:0] cur_id = 7'h00;
    logic       cur_rnw = 1'b0;
    int n_valid = 0, n_fin = 0, n_wrr = 0, n_rdv = 0, last_valid_cyc = 0, fin_cyc = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_rd = 8'h00;

    // Monitor: scoreboard pops on bus pulses and read handshakes, plus invariants
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_valid) begin
                n_valid++;
                last_valid_cyc = cyc;
                chk("bus_pulse_expected", exp_bus.size() != 0, 1);
                if (exp_bus.size() != 0) chk("bus_data", bus_data, exp_bus.pop_front());
            end
            if (bus_finished) begin
                n_fin++;
                fin_cyc = cyc;
                chk("fin_done", done, 1);
                chk("fin_no_valid", bus_valid, 0);
            end
            if (wr_ready) n_wrr++;
            if (rd_valid) n_rdv++;
            if (prev_hold) chk("rd_hold", {rd_valid, rd_data}, {1'b1, prev_rd});
            if (rd_valid && rd_ready) begin
                chk("rd_expected", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) chk("rd_data", rd_data, exp_rd.pop_front());
            end
            if (busy) chk("bus_id_busy", {bus_rnw, bus_slave_id}, {cur_rnw, cur_id});
            else chk("bus_id_idle", {bus_rnw, bus_slave_id}, 0);
            prev_hold = rd_valid && !rd_ready;
            prev_rd = rd_data;
        end else prev_hold = 1'b0;
    end

    function automatic logic [7:0] byte_of(input txn_t r, input int i);
        return i < 8 ? r.d[i] : 8'(i * 37 + 5);
    endfunction

    // Run one transaction starting at a negedge; optionally leave the next command held
    task automatic run_txn(input txn_t rec, input bit hold, input txn_t nxt, input bit immediate, input string tag);
        int s_valid, s_fin, s_wrr, s_rdv, k, r, st, t;
        bit seen, bad_echo;
        logic [7:0] wb [$];
        s_valid = n_valid; s_fin = n_fin; s_wrr = n_wrr; s_rdv = n_rdv;
        bad_echo = rec.rnw && (rec.echo != {1'b0, rec.id});
        cur_id = rec.id;
        cur_rnw = rec.rnw;
        src[0] = rec.echo;
        exp_bus.push_back({2'b00, rec.addr});
        for (int i = 0; i < rec.len; i++) begin
            src[i + 1] = byte_of(rec, i);
            if (!rec.rnw) begin
                wb.push_back(byte_of(rec, i));
                exp_bus.push_back(byte_of(rec, i));
            end else if (!bad_echo) begin
                exp_bus.push_back(8'h00);
                exp_rd.push_back(byte_of(rec, i));
            end
        end
        if (!cmd_valid) begin
            cmd_valid = 1'b1;
            cmd_slave_id = rec.id;
            cmd_rnw = rec.rnw;
            cmd_addr = rec.addr;
            cmd_len = LEN_W'(rec.len);
        end
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (immediate) chk({tag, "_accept_latency"}, t, 0);
        @(posedge clk); #1;
        if (hold) begin
            cmd_slave_id = nxt.id;
            cmd_rnw = nxt.rnw;
            cmd_addr = nxt.addr;
            cmd_len = LEN_W'(nxt.len);
        end else begin
            cmd_valid = 1'b0;
            cmd_slave_id = 7'h7f;
            cmd_rnw = ~rec.rnw;
            cmd_addr = 6'h3f;
            cmd_len = '1;
        end
        k = 0; r = 0; st = 0; seen = 0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(posedge clk); #1;
            wr_valid = !rec.rnw && k < rec.len && ($urandom_range(0, 2) != 0);
            wr_data = wr_valid ? wb[k] : 8'h00;
            if (rd_valid && r == rec.stall_byte && st < rec.stall_cyc) begin
                rd_ready = 1'b0;
                st++;
            end else rd_ready = 1'b1;
            @(negedge clk);
            if (wr_valid && wr_ready) k++;
            if (rd_valid && rd_ready) r++;
            if (done) seen = 1;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        chk({tag, "_done_seen"}, seen, 1);
        @(negedge clk);
        chk({tag, "_idle_after"}, {cmd_ready, busy, done}, 3'b100);
        chk({tag, "_pulses"}, n_valid - s_valid, rec.exp_pulses);
        chk({tag, "_fin_count"}, n_fin - s_fin, 1);
        chk({tag, "_nack"}, nack, rec.exp_nack);
        chk({tag, "_bus_q_empty"}, exp_bus.size(), 0);
        chk({tag, "_rd_q_empty"}, exp_rd.size(), 0);
        if (!rec.rnw || bad_echo) chk({tag, "_fin_gap"}, fin_cyc - last_valid_cyc, 1);
        if (rec.rnw) chk({tag, "_rd_count"}, r, bad_echo ? 0 : rec.len);
        else chk({tag, "_wr_count"}, k, rec.len);
        if (bad_echo) chk({tag, "_no_rd_valid"}, n_rdv - s_rdv, 0);
        if (!rec.rnw && rec.len == 0) chk({tag, "_no_wr_ready"}, n_wrr - s_wrr, 0);
        exp_bus.delete();
        exp_rd.delete();
    endtask

    txn_t tbl [7];
    txn_t none, ta, tb_;
    int   r;
    bit   fin_seen;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        none = '{rnw: 0, id: 0, addr: 0, len: 0, echo: 0, d: '{default: 8'h00},
                 stall_byte: -1, stall_cyc: 0, exp_nack: 0, exp_pulses: 0};
        tbl[0] = '{rnw: 0, id: 7'h03, addr: 6'h00, len: 2, echo: 8'h00,
                   d: '{8'h5A, 8'hC3, 0, 0, 0, 0, 0, 0}, stall_byte: -1, stall_cyc: 0, exp_nack: 0, exp_pulses: 3};
        tbl[1] = '{rnw: 1, id: 7'h03, addr: 6'h02, len: 4, echo: 8'h03,
                   d: '{8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0}, stall_byte: 1, stall_cyc: 5, exp_nack: 0, exp_pulses: 5};
        tbl[2] = '{rnw: 1, id: 7'h05, addr: 6'h01, len: 3, echo: 8'h00,
                   d: '{8'h99, 8'h98, 8'h97, 0, 0, 0, 0, 0}, stall_byte: -1, stall_cyc: 0, exp_nack: 1, exp_pulses: 1};
        tbl[3] = '{rnw: 0, id: 7'h09, addr: 6'h05, len: 0, echo: 8'h00,
                   d: '{default: 8'h00}, stall_byte: -1, stall_cyc: 0, exp_nack: 1, exp_pulses: 1};
        tbl[4] = '{rnw: 1, id: 7'h03, addr: 6'h10, len: 3, echo: 8'h03,
                   d: '{8'hA1, 8'hB2, 8'hC3, 0, 0, 0, 0, 0}, stall_byte: 0, stall_cyc: 2, exp_nack: 0, exp_pulses: 4};
        tbl[5] = '{rnw: 0, id: 7'h7f, addr: 6'h3f, len: 63, echo: 8'h00,
                   d: '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h55, 8'hAA, 8'h0F, 8'hF0}, stall_byte: -1, stall_cyc: 0, exp_nack: 0, exp_pulses: 64};
        tbl[6] = '{rnw: 1, id: 7'h40, addr: 6'h07, len: 0, echo: 8'h40,
                   d: '{default: 8'h00}, stall_byte: -1, stall_cyc: 0, exp_nack: 0, exp_pulses: 1};

        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {cmd_ready, wr_ready, rd_valid, rd_data, bus_data, bus_valid, bus_finished,
             bus_slave_id, bus_rnw, busy, done, nack},
            {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0});
        rst_sync = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 7; i++) run_txn(tbl[i], 0, none, 0, $sformatf("tbl%0d", i));

        ta = '{rnw: 0, id: 7'h12, addr: 6'h04, len: 3, echo: 8'h00,
               d: '{8'hAA, 8'hBB, 8'hCC, 0, 0, 0, 0, 0}, stall_byte: -1, stall_cyc: 0, exp_nack: 0, exp_pulses: 4};
        tb_ = '{rnw: 1, id: 7'h21, addr: 6'h07, len: 2, echo: 8'h21,
                d: '{8'h5C, 8'h6D, 0, 0, 0, 0, 0, 0}, stall_byte: -1, stall_cyc: 0, exp_nack: 0, exp_pulses: 3};
        run_txn(ta, 1, tb_, 0, "hold_a");
        run_txn(tb_, 0, none, 1, "hold_b");

        mon_en = 1'b0;
        src[0] = 8'h03;
        src[1] = 8'h11; src[2] = 8'h22; src[3] = 8'h33; src[4] = 8'h44;
        cmd_valid = 1'b1; cmd_slave_id = 7'h03; cmd_rnw = 1'b1; cmd_addr = 6'h02; cmd_len = LEN_W'(4);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        r = 0;
        fin_seen = 0;
        for (int c = 0; c < 200 && r < 2; c++) begin
            @(negedge clk);
            if (rd_valid && rd_ready) r++;
            if (bus_finished) fin_seen = 1;
        end
        chk("rst_two_bytes", r, 2);
        rst_sync = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs",
            {cmd_ready, wr_ready, rd_valid, bus_data, bus_valid, bus_finished,
             bus_slave_id, bus_rnw, busy, done, nack},
            {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("rst_no_fin_before", fin_seen, 0);
        rst_sync = 1'b0;
        @(negedge clk);
        chk("rst_stays_idle", {cmd_ready, busy, bus_finished, done, rd_valid}, 5'b10000);
        mon_en = 1'b1;
        run_txn(tbl[0], 0, none, 1, "post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/scarf_byte_master.md
SCARF_BYTE_MASTER -- requirements
Module: scarf_byte_master

Interface
REQ-001 SHALL have parameter LEN_W, default 6, width of cmd_len.
REQ-002 SHALL have ports:
- clk  input  1  sole clock, rising edge.
- rst_sync  input  1  reset, synchronous, active-high.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accept.
- cmd_slave_id  input  7  target slave ID.
- cmd_rnw  input  1  1=read, 0=write.
- cmd_addr  input  6  start register address.
- cmd_len  input  LEN_W  data byte count, 0 allowed.
- wr_valid  input  1  write byte offered.
- wr_ready  output  1  write byte accept.
- wr_data  input  8  write byte.
- rd_valid  output  1  read byte available.
- rd_ready  input  1  read byte consumed.
- rd_data  output  8  read byte.
- bus_data  output  8  byte to regmap data_in.
- bus_valid  output  1  to regmap data_in_valid.
- bus_finished  output  1  to regmap data_in_finished.
- bus_slave_id  output  7  to regmap slave_id.
- bus_rnw  output  1  to regmap rnw.
- bus_rdata  input  8  from regmap read_data_out (combinational there).
- busy  output  1  transaction in progress.
- done  output  1  one-cycle end pulse.
- nack  output  1  last read got a bad slave echo.
REQ-003 SHALL register every output.

Function
REQ-004 SHALL implement FSM IDLE, ADDR, DATA, FINISH.
REQ-005 IDLE:
- cmd_ready=1 and busy=0.
- cmd_valid&cmd_ready latches all cmd_* fields and moves to ADDR.
REQ-006 bus_slave_id and bus_rnw SHALL equal the latched values from ADDR through FINISH, and SHALL be 0 in IDLE (slave ID 0 is reserved).
REQ-007 ADDR:
- lasts exactly one cycle, with bus_valid=1 and bus_data={2'b00,addr}.
- write: go to DATA, or to FINISH if len=0.
REQ-008 Read ADDR:
- sample bus_rdata in the ADDR cycle and compare with {1'b0,slave_id}.
- mismatch: nack=1, go to FINISH, issue no data pulses.
- match: nack=0.
REQ-009 Write DATA:
- wr_ready=1 while bytes remain.
- each wr handshake at cycle c yields bus_valid=1, bus_data=wr_data at c+1.
- bus_valid=0 in cycles without a handshake.
REQ-010 Read DATA:
- issue a one-cycle bus_valid=1 (bus_data=8'h00) only when rd_valid=0 and no pulse is outstanding.
- capture bus_rdata into rd_data in the pulse cycle; rd_valid=1 next cycle.
REQ-011 rd_valid SHALL hold with rd_data stable until rd_ready; no further pulse issues while rd_valid=1.
REQ-012 Byte counter:
- decrements per bus_valid data pulse.
- after the pulse taking it to 0, FINISH follows next cycle.
REQ-013 FINISH:
- lasts one cycle, with bus_finished=1, bus_valid=0 and done=1.
- then IDLE; cmd_ready=1 the cycle after.
REQ-014 A read SHALL finish only after the last rd byte is consumed.
REQ-015 Address overrun is not checked; the master always emits exactly cmd_len data pulses, and the slave saturates.
REQ-016 cmd_valid outside IDLE SHALL be ignored.
REQ-017 wr_valid outside write DATA SHALL be ignored, with wr_ready=0.
REQ-018 nack SHALL hold until the next read ADDR cycle.

Reset
REQ-019 rst_sync=1 at a clock edge SHALL force IDLE, counter 0 and every output 0 except cmd_ready=1, from any state.
REQ-020 Reset mid-transaction SHALL produce no bus_finished or done pulse and discard any pending rd byte.

Verification
REQ-021 Write, slave 3, addr 0, len 2, bytes 5A,C3 -> bus_data 00,5A,C3 on consecutive bus_valid pulses, bus_finished one cycle after the last pulse, done=1, nack=0.
REQ-022 Read, slave 3, addr 2, len 4; model echo 03 then bytes 11,22,33,44; rd_ready low for 5 cycles on byte 2 -> rd_data 11,22,33,44 in order, exactly 5 bus_valid pulses total.
REQ-023 Read, slave 5, bus_rdata 00 -> nack=1, no rd_valid, bus_finished the cycle after ADDR.
REQ-024 Write, len 0 -> one bus_valid (addr) then bus_finished; wr_ready never 1.
REQ-025 Reset during read after 2 bytes -> next cycle all bus outputs 0, rd_valid=0, no bus_finished, cmd_ready=1.
REQ-026 Second cmd_valid held during busy -> accepted only the cycle after done; no field corruption in the first transaction.
